// File: rtl/tsp_file_writer_if.sv
// Interface bundling the writer's control, city RAM read port and byte-stream channel.
// master is the writer; slave is the surrounding host/RAM/sink.
interface tsp_file_writer_if #(
   parameter int unsigned PRECISION     = 32,
   parameter int unsigned MAX_NODE_BITS = 13
);
   logic                       start;
   logic [MAX_NODE_BITS-1:0]   nnodes;
   logic                       busy;
   logic                       done;
   logic [MAX_NODE_BITS-1:0]   ram_addr;
   logic                       ram_rd_en;
   logic [2*PRECISION-1:0]     ram_rdata;
   logic [7:0]                 out_data;
   logic                       out_valid;
   logic                       out_ready;

   modport master (
      input  start, nnodes, ram_rdata, out_ready,
      output busy, done, ram_addr, ram_rd_en, out_data, out_valid
   );

   modport slave (
      output start, nnodes, ram_rdata, out_ready,
      input  busy, done, ram_addr, ram_rd_en, out_data, out_valid
   );
endinterface

// File: rtl/tsp_file_writer.sv
// Dumps the city RAM as a TSPLIB-style ASCII stream (DIMENSION, NODE_COORD_SECTION, lines, EOF),
// one byte per valid/ready handshake, using a shared double-dabble number emitter.
module tsp_file_writer #(
   parameter int unsigned PRECISION     = 32,
   parameter int unsigned MAX_NODE_BITS = 13,
   parameter int unsigned RAM_LATENCY   = 2,
   parameter logic [7:0]  NEWLINE       = 8'd13
) (
   input  logic              clk,
   input  logic              rst,
   tsp_file_writer_if.master bus
);

   localparam int unsigned NDIG  = (PRECISION * 30103 + 99999) / 100000;
   localparam int unsigned BCDW  = 4 * NDIG;
   localparam int unsigned IDXW  = MAX_NODE_BITS + 1;
   localparam int unsigned CNTW  = $clog2(PRECISION + 1);
   localparam int unsigned DIGW  = $clog2(NDIG);
   localparam int unsigned WAITW = $clog2(RAM_LATENCY + 1);
   localparam int unsigned LITN  = 34;

   // Literal ROM: "DIMENSION: " | "NODE_COORD_SECTION" CR | "EOF" CR
   localparam logic [LITN*8-1:0] LIT = {"DIMENSION: ", "NODE_COORD_SECTION", NEWLINE, "EOF", NEWLINE};
   localparam logic [5:0] P_DIM_END  = 6'd10;
   localparam logic [5:0] P_NODE_END = 6'd29;
   localparam logic [5:0] P_EOF_END  = 6'd33;

   typedef enum logic [3:0] {
      S_IDLE, S_HDR_DIM, S_HDR_NODE, S_RD_REQ, S_RD_WAIT,
      S_LINE, S_TAIL, S_CONV, S_EMIT_NUM, S_DONE
   } state_t;

   state_t                   r_state;
   state_t                   r_ret;
   logic                     r_busy;
   logic                     r_done;
   logic [MAX_NODE_BITS-1:0] r_ram_addr;
   logic                     r_rd_en;
   logic [7:0]               r_out_data;
   logic                     r_out_valid;
   logic [MAX_NODE_BITS-1:0] r_n;
   logic [IDXW-1:0]          r_idx;
   logic [5:0]               r_ptr;
   logic [2:0]               r_fld;
   logic [WAITW-1:0]         r_wait;
   logic [PRECISION-1:0]     r_x;
   logic [PRECISION-1:0]     r_y;
   logic [PRECISION-1:0]     r_bin;
   logic [BCDW-1:0]          r_bcd;
   logic [CNTW-1:0]          r_cnt;
   logic [DIGW-1:0]          r_dig;
   logic                     r_seen;

   logic                     w_can_load;
   logic [8:0]               w_lit_pos;
   logic [7:0]               w_lit;
   logic [5:0]               w_dig_pos;
   logic [3:0]               w_digit;
   logic [IDXW-1:0]          w_idx_p1;
   logic [BCDW-1:0]          w_bcd_adj;

   // Add-3 correction of every BCD digit >= 5 before each shift.
   function automatic logic [BCDW-1:0] dd_adj(input logic [BCDW-1:0] v);
      logic [BCDW-1:0] r;
      r = v;
      for (int k = 0; k < int'(NDIG); k++) begin
         if (r[4*k +: 4] >= 4'd5) r[4*k +: 4] = r[4*k +: 4] + 4'd3;
      end
      return r;
   endfunction

   // A new byte may be loaded when the output slot is empty or being drained this edge.
   assign w_can_load = !r_out_valid || bus.out_ready;
   assign w_lit_pos  = {6'(6'(LITN - 1) - r_ptr), 3'b000};
   assign w_lit      = LIT[w_lit_pos +: 8];
   assign w_dig_pos  = {r_dig, 2'b00};
   assign w_digit    = r_bcd[w_dig_pos +: 4];
   assign w_idx_p1   = r_idx + IDXW'(1);
   assign w_bcd_adj  = dd_adj(r_bcd);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= S_IDLE;
         r_ret       <= S_IDLE;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_ram_addr  <= '0;
         r_rd_en     <= 1'b0;
         r_out_data  <= '0;
         r_out_valid <= 1'b0;
         r_n         <= '0;
         r_idx       <= '0;
         r_ptr       <= '0;
         r_fld       <= '0;
         r_wait      <= '0;
         r_x         <= '0;
         r_y         <= '0;
         r_bin       <= '0;
         r_bcd       <= '0;
         r_cnt       <= '0;
         r_dig       <= '0;
         r_seen      <= 1'b0;
      end else begin
         r_rd_en <= 1'b0;
         r_done  <= 1'b0;
         if (r_out_valid && bus.out_ready) r_out_valid <= 1'b0;

         case (r_state)
            S_IDLE: begin
               if (bus.start) begin
                  r_n     <= bus.nnodes;
                  r_busy  <= 1'b1;
                  r_ptr   <= '0;
                  r_fld   <= '0;
                  r_idx   <= '0;
                  r_bcd   <= '0;
                  r_cnt   <= '0;
                  r_state <= S_HDR_DIM;
               end
            end

            S_HDR_DIM: begin
               if (r_fld == 3'd0) begin
                  if (w_can_load) begin
                     r_out_data  <= w_lit;
                     r_out_valid <= 1'b1;
                     r_ptr       <= r_ptr + 6'd1;
                     if (r_ptr == P_DIM_END) begin
                        r_bin   <= PRECISION'(r_n);
                        r_ret   <= S_HDR_DIM;
                        r_fld   <= 3'd1;
                        r_state <= S_CONV;
                     end
                  end
               end else if (w_can_load) begin
                  r_out_data  <= NEWLINE;
                  r_out_valid <= 1'b1;
                  r_state     <= S_HDR_NODE;
               end
            end

            S_HDR_NODE: begin
               if (w_can_load) begin
                  r_out_data  <= w_lit;
                  r_out_valid <= 1'b1;
                  r_ptr       <= r_ptr + 6'd1;
                  if (r_ptr == P_NODE_END) r_state <= (r_n == '0) ? S_TAIL : S_RD_REQ;
               end
            end

            S_RD_REQ: begin
               r_ram_addr <= r_idx[MAX_NODE_BITS-1:0];
               r_rd_en    <= 1'b1;
               r_wait     <= '0;
               r_state    <= S_RD_WAIT;
            end

            S_RD_WAIT: begin
               if (r_wait == WAITW'(RAM_LATENCY)) begin
                  r_x     <= bus.ram_rdata[PRECISION-1:0];
                  r_y     <= bus.ram_rdata[2*PRECISION-1:PRECISION];
                  r_fld   <= 3'd0;
                  r_state <= S_LINE;
               end else begin
                  r_wait <= r_wait + WAITW'(1);
               end
            end

            // Field sequence: index, SP, X, SP, Y, CR; numbers detour through CONV.
            S_LINE: begin
               case (r_fld)
                  3'd0: begin
                     r_bin   <= PRECISION'(w_idx_p1);
                     r_ret   <= S_LINE;
                     r_fld   <= 3'd1;
                     r_state <= S_CONV;
                  end
                  3'd1, 3'd3: begin
                     if (w_can_load) begin
                        r_out_data  <= 8'h20;
                        r_out_valid <= 1'b1;
                        r_fld       <= r_fld + 3'd1;
                     end
                  end
                  3'd2: begin
                     r_bin   <= r_x;
                     r_ret   <= S_LINE;
                     r_fld   <= 3'd3;
                     r_state <= S_CONV;
                  end
                  3'd4: begin
                     r_bin   <= r_y;
                     r_ret   <= S_LINE;
                     r_fld   <= 3'd5;
                     r_state <= S_CONV;
                  end
                  default: begin
                     if (w_can_load) begin
                        r_out_data  <= NEWLINE;
                        r_out_valid <= 1'b1;
                        r_idx       <= w_idx_p1;
                        r_state     <= (w_idx_p1 == {1'b0, r_n}) ? S_TAIL : S_RD_REQ;
                     end
                  end
               endcase
            end

            S_TAIL: begin
               if (w_can_load) begin
                  r_out_data  <= w_lit;
                  r_out_valid <= 1'b1;
                  r_ptr       <= r_ptr + 6'd1;
                  if (r_ptr == P_EOF_END) r_state <= S_DONE;
               end
            end

            S_CONV: begin
               r_bcd <= {w_bcd_adj[BCDW-2:0], r_bin[PRECISION-1]};
               r_bin <= {r_bin[PRECISION-2:0], 1'b0};
               if (r_cnt == CNTW'(PRECISION - 1)) begin
                  r_cnt   <= '0;
                  r_dig   <= DIGW'(NDIG - 1);
                  r_seen  <= 1'b0;
                  r_state <= S_EMIT_NUM;
               end else begin
                  r_cnt <= r_cnt + CNTW'(1);
               end
            end

            // Leading zeros are skipped; digit 0 is always printed.
            S_EMIT_NUM: begin
               if (w_digit == 4'd0 && !r_seen && r_dig != '0) begin
                  r_dig <= r_dig - DIGW'(1);
               end else if (w_can_load) begin
                  r_out_data  <= 8'h30 + {4'h0, w_digit};
                  r_out_valid <= 1'b1;
                  r_seen      <= 1'b1;
                  if (r_dig == '0) begin
                     r_bcd   <= '0;
                     r_state <= r_ret;
                  end else begin
                     r_dig <= r_dig - DIGW'(1);
                  end
               end
            end

            S_DONE: begin
               if (w_can_load) begin
                  r_done  <= 1'b1;
                  r_busy  <= 1'b0;
                  r_state <= S_IDLE;
               end
            end

            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.busy      = r_busy;
   assign bus.done      = r_done;
   assign bus.ram_addr  = r_ram_addr;
   assign bus.ram_rd_en = r_rd_en;
   assign bus.out_data  = r_out_data;
   assign bus.out_valid = r_out_valid;

endmodule
